// File: rtl/argmax_unit_pkg.sv
// Shared network-stage definitions: argmax FSM encoding and default vector geometry.
package argmax_unit_pkg;

  localparam int N_CLASS_DEF = 10;
  localparam int ACC_W_DEF   = 32;
  localparam int IDX_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_unit_if.sv
// Score-vector in / argmax-result out bundle; signal suffixes are from the argmax block's side.
interface argmax_unit_if #(
  parameter int N_CLASS = argmax_unit_pkg::N_CLASS_DEF,
  parameter int ACC_W   = argmax_unit_pkg::ACC_W_DEF,
  parameter int IDX_W   = argmax_unit_pkg::IDX_W_DEF
) ();

  logic                       valid_i;
  logic                       ready_o;
  logic [N_CLASS*ACC_W-1:0]   acc_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [IDX_W-1:0]           class_o;
  logic signed [ACC_W-1:0]    max_o;
  logic                       busy_o;

  modport slave (
    input  valid_i, acc_i, ready_i,
    output ready_o, valid_o, class_o, max_o, busy_o
  );

  modport master (
    output valid_i, acc_i, ready_i,
    input  ready_o, valid_o, class_o, max_o, busy_o
  );

endinterface

// File: rtl/argmax_cmp.sv
// Combinational signed compare-and-select; the candidate wins only when strictly greater,
// so ties keep the incumbent (lower) index.
module argmax_cmp #(
  parameter int ACC_W = 32,
  parameter int IDX_W = 4
) (
  input  logic signed [ACC_W-1:0] cur_val_i,
  input  logic        [IDX_W-1:0] cur_idx_i,
  input  logic signed [ACC_W-1:0] cand_val_i,
  input  logic        [IDX_W-1:0] cand_idx_i,
  output logic signed [ACC_W-1:0] sel_val_o,
  output logic        [IDX_W-1:0] sel_idx_o
);

  logic take;

  assign take      = cand_val_i > cur_val_i;
  assign sel_val_o = take ? cand_val_i : cur_val_i;
  assign sel_idx_o = take ? cand_idx_i : cur_idx_i;

endmodule

// File: rtl/argmax_unit.sv
// Sequential argmax over an N_CLASS score vector: one element per cycle, result N_CLASS cycles
// after capture, held in DONE until taken; no new vector is accepted until back in IDLE.
module argmax_unit
  import argmax_unit_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clear_i,
  argmax_unit_if.slave  bus
);

  // One extra pointer bit lets the scan spend a final cycle committing the result.
  localparam int              PTR_W    = IDX_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CLASS);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic signed [ACC_W-1:0] buf_q [N_CLASS];
  logic signed [ACC_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]        run_idx_q, run_idx_d;
  logic signed [ACC_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]        cls_q, cls_d;
  logic [IDX_W-1:0]        rd_idx;
  logic signed [ACC_W-1:0] rd_val;
  logic signed [ACC_W-1:0] sel_val;
  logic [IDX_W-1:0]        sel_idx;
  logic                    accept;

  assign accept = (state_q == ST_IDLE) && bus.valid_i && !clear_i;
  assign rd_idx = (ptr_q < LAST_PTR) ? ptr_q[IDX_W-1:0] : '0;
  assign rd_val = buf_q[rd_idx];

  argmax_cmp #(
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .cur_val_i  (run_max_q),
    .cur_idx_i  (run_idx_q),
    .cand_val_i (rd_val),
    .cand_idx_i (rd_idx),
    .sel_val_o  (sel_val),
    .sel_idx_o  (sel_idx)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.valid_i) state_d = (N_CLASS == 1) ? ST_DONE : ST_SCAN;
        ST_SCAN: if (ptr_q == LAST_PTR) state_d = ST_DONE;
        ST_DONE: if (bus.ready_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready_o = (state_q == ST_IDLE);
    bus.valid_o = (state_q == ST_DONE);
    bus.busy_o  = (state_q == ST_SCAN) || (state_q == ST_DONE);
    bus.class_o = cls_q;
    bus.max_o   = max_q;
  end

  always_comb begin
    ptr_d     = ptr_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    max_d     = max_q;
    cls_d     = cls_q;
    if (clear_i) begin
      ptr_d     = '0;
      run_max_d = '0;
      run_idx_d = '0;
    end else if (accept) begin
      ptr_d     = PTR_W'(1);
      run_max_d = bus.acc_i[ACC_W-1:0];
      run_idx_d = '0;
      if (N_CLASS == 1) begin
        max_d = bus.acc_i[ACC_W-1:0];
        cls_d = '0;
      end
    end else if (state_q == ST_SCAN) begin
      if (ptr_q == LAST_PTR) begin
        max_d = run_max_q;
        cls_d = run_idx_q;
        ptr_d = '0;
      end else begin
        run_max_d = sel_val;
        run_idx_d = sel_idx;
        ptr_d     = ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      max_q     <= '0;
      cls_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      max_q     <= max_d;
      cls_q     <= cls_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_CLASS; k++) buf_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < N_CLASS; k++) buf_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_CLASS; k++) buf_q[k] <= bus.acc_i[k*ACC_W +: ACC_W];
    end
  end

endmodule
